// File: rtl/exception_ctrl_if.sv
// Exception-path bundle between maindec/datapath and the exception controller.
// master = datapath side (drives PC/cause), slave = exception_ctrl.
interface exception_ctrl_if #(
   parameter int N     = 64,
   parameter int CNT_W = 8
);
   logic [N-1:0]     PC;
   logic [3:0]       EStatus;
   logic             ERet;
   logic             Exc;
   logic [N-1:0]     ExcVector;
   logic             ERetTaken;
   logic [N-1:0]     ELR;
   logic [N-1:0]     ESR;
   logic             ExtIAck;
   logic             InHandler;
   logic             Halt;
   logic [CNT_W-1:0] IrqCount;

   modport master (
      output PC, EStatus, ERet,
      input  Exc, ExcVector, ERetTaken, ELR, ESR, ExtIAck, InHandler, Halt, IrqCount
   );

   modport slave (
      input  PC, EStatus, ERet,
      output Exc, ExcVector, ERetTaken, ELR, ESR, ExtIAck, InHandler, Halt, IrqCount
   );
endinterface

// File: rtl/exception_ctrl.sv
// Exception controller for single-cycle LEGv8: takes/returns exceptions, holds ELR/ESR, halts on double fault.
// Latency: redirect (Exc/ERetTaken) is same-cycle comb; ELR/ESR/ack visible next cycle. No backpressure.
module exception_ctrl #(
   parameter int           N          = 64,
   parameter logic [N-1:0] EXC_VECTOR = 64'hD8,
   parameter int           CNT_W      = 8
) (
   input logic             clk,
   input logic             reset,
   exception_ctrl_if.slave bus
);

   localparam logic [3:0]       ES_NONE = 4'b0000;
   localparam logic [3:0]       ES_IRQ  = 4'b0001;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HANDLER = 2'd1,
      ST_HALTED  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic es_any;
   logic es_irq;
   logic es_inv;

   logic exc;
   logic eret_taken;
   logic cap_elr;
   logic cap_esr;
   logic irq_take;
   logic in_handler;
   logic halt;

   logic [N-1:0]     elr;
   logic [N-1:0]     esr;
   logic             ext_iack;
   logic [CNT_W-1:0] irq_count;

   // Any nonzero cause other than IRQ is treated as invalid-class.
   assign es_any = (bus.EStatus != ES_NONE);
   assign es_irq = (bus.EStatus == ES_IRQ);
   assign es_inv = es_any & ~es_irq;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (es_any) state_nxt = ST_HANDLER;
         end
         ST_HANDLER: begin
            // ERET wins over any simultaneous cause; IRQ stays masked.
            if (bus.ERet)       state_nxt = ST_RUN;
            else if (es_inv)    state_nxt = ST_HALTED;
         end
         ST_HALTED: begin
            state_nxt = ST_HALTED;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   always_comb begin
      exc        = 1'b0;
      eret_taken = 1'b0;
      cap_elr    = 1'b0;
      cap_esr    = 1'b0;
      irq_take   = 1'b0;
      in_handler = 1'b0;
      halt       = 1'b0;
      case (state)
         ST_RUN: begin
            exc      = reset & es_any;
            cap_elr  = exc;
            cap_esr  = exc;
            irq_take = exc & es_irq;
         end
         ST_HANDLER: begin
            in_handler = 1'b1;
            eret_taken = reset & bus.ERet;
            // Double fault records its cause but keeps ELR pointing at the first fault.
            cap_esr    = reset & ~bus.ERet & es_inv;
         end
         ST_HALTED: begin
            halt = 1'b1;
         end
         default: begin
            halt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         elr       <= '0;
         esr       <= '0;
         ext_iack  <= 1'b0;
         irq_count <= '0;
      end else begin
         ext_iack <= irq_take;
         if (cap_elr) begin
            elr <= bus.PC;
         end
         if (cap_esr) begin
            esr <= {{(N-4){1'b0}}, bus.EStatus};
         end
         if (irq_take && (irq_count != CNT_MAX)) begin
            irq_count <= irq_count + CNT_ONE;
         end
      end
   end

   assign bus.Exc       = exc;
   assign bus.ExcVector = EXC_VECTOR;
   assign bus.ERetTaken = eret_taken;
   assign bus.ELR       = elr;
   assign bus.ESR       = esr;
   assign bus.ExtIAck   = ext_iack;
   assign bus.InHandler = in_handler;
   assign bus.Halt      = halt;
   assign bus.IrqCount  = irq_count;

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Consumer end of the maindec exception interface in the single-cycle LEGv8 processor.
- Takes maindec's EStatus and ERet every cycle and decides whether an exception is taken.
- Holds ELR/ESR state, redirects the PC to the vector or back to ELR, and returns a one-cycle acknowledge to the external interrupt source.
- Nested exceptions are masked inside the handler; an invalid opcode inside the handler is a double fault and halts the core.

Parameters:
- N, 64, datapath/PC width.
- EXC_VECTOR, 64'hD8, PC loaded when an exception is taken.
- CNT_W, 8, width of the saturating IRQ counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous reset, active-low (asserted when 0)
- PC  in  N  address of the instruction in the current cycle
- EStatus  in  4  maindec cause: 0000 none, 0001 external IRQ, 0010 invalid opcode; any other nonzero value is treated as invalid-class
- ERet  in  1  maindec: current instruction is ERET
- Exc  out  1  exception taken this cycle (comb); squashes writes and selects ExcVector
- ExcVector  out  N  constant EXC_VECTOR
- ERetTaken  out  1  ERET honoured this cycle (comb); selects ELR as next PC
- ELR  out  N  exception link register (address of the faulting or interrupted instruction)
- ESR  out  N  syndrome, {zero-ext, EStatus captured}
- ExtIAck  out  1  one-cycle registered acknowledge of an IRQ
- InHandler  out  1  state == HANDLER
- Halt  out  1  double-fault halt, sticky until reset
- IrqCount  out  CNT_W  saturating count of IRQs taken

Behaviour:
- States: RUN, HANDLER, HALTED.
- Reset (reset==0 at an edge):
  - state=RUN; ELR=0, ESR=0, ExtIAck=0, IrqCount=0, Halt=0.
  - While reset==0, Exc and ERetTaken are forced to 0.
  - Reset mid-handler or in HALTED returns to RUN with no residual ack.
- Combinational outputs:
  - Exc = reset & (state==RUN) & (EStatus!=0).
  - ERetTaken = reset & (state==HANDLER) & ERet.
  - InHandler = (state==HANDLER). Halt = (state==HALTED).
- RUN:
  - EStatus!=0 → ELR<=PC, ESR<={N-4 zeros, EStatus}, state<=HANDLER.
  - If EStatus==0001: ExtIAck<=1 next cycle, IrqCount<=IrqCount+1 (saturates at all-ones, never wraps).
  - ERet in RUN is ignored: ERetTaken=0, no state change.
- HANDLER:
  - ERet → state<=RUN, ERetTaken=1 the same cycle. ELR/ESR are retained, not cleared.
  - EStatus==0001 (IRQ) is masked: no ack, no capture. ExtIRQ is level-held by the source and is taken after return.
  - Any other nonzero EStatus (invalid class) while ERet==0 → state<=HALTED, ESR<={…,EStatus}. ELR is unchanged so the original return address is preserved.
  - ERet and EStatus==0001 in the same cycle: ERet wins, state<=RUN, no ack that cycle. The IRQ is taken on the following cycle if still asserted.
- HALTED: Exc=0, ERetTaken=0, all registers frozen; exit only via reset.
- ExtIAck:
  - Registered pulse, exactly one cycle, on the cycle after the IRQ is taken. Deasserts the following cycle regardless of ExtIRQ.
  - An IRQ re-taken right after return gives a fresh pulse.
- Latency: redirect is 0-cycle (comb, same-cycle PC mux); ELR/ESR are visible the cycle after capture.

Test Plan:
- Reset & idle: reset=0 for 2 cycles, then EStatus=0, ERet=0 → all outputs 0, state RUN, Exc=0, IrqCount=0.
- Invalid opcode: PC=0x40, EStatus=0010 for 1 cycle →
  - same cycle: Exc=1.
  - next cycle: ELR=0x40, ESR=0x2, InHandler=1, ExtIAck=0.
  - then ERet=1 → ERetTaken=1, next cycle InHandler=0.
- IRQ handshake: PC=0x100, EStatus=0001 held 3 cycles →
  - Exc=1 only in cycle 1.
  - ExtIAck=1 only in cycle 2.
  - ELR=0x100, ESR=0x1, IrqCount=1.
  - cycles 2–3 masked: no second ack.
- ERet vs IRQ collision: in HANDLER, ERet=1 with EStatus=0001 →
  - ERetTaken=1, Exc=0, state RUN.
  - next cycle with EStatus=0001 → Exc=1, ack one cycle later, IrqCount increments.
- Double fault: in HANDLER with ELR=0x40, EStatus=0010 →
  - next cycle Halt=1, ELR=0x40, ESR=0x2.
  - further EStatus/ERet activity → no change.
  - reset=0 → Halt=0, RUN.
- Counter saturation (CNT_W=2): take 5 IRQs, each followed by ERet → IrqCount reads 1,2,3,3,3.
